// File: rtl/regfile_pkg.sv
// Shared widths and the write-request type used on the register-file write-back path.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: datapath and long-latency sources in, register-file write port
// and hazard/status signals out.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    import regfile_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                      dp_we;
    logic [ADDR_W-1:0]         dp_waddr;
    logic [DATA_W-1:0]         dp_wdata;
    logic                      lc_valid;
    logic                      lc_ready;
    logic [ADDR_W-1:0]         lc_waddr;
    logic [DATA_W-1:0]         lc_wdata;
    logic                      FR_WE;
    logic [ADDR_W-1:0]         FR_Waddr;
    logic [DATA_W-1:0]         FR_Wdata;
    logic [(1 << ADDR_W)-1:0]  pend_mask;
    logic                      dp_stall;
    logic [CNT_W-1:0]          q_count;

    modport master (
        output dp_we, dp_waddr, dp_wdata, lc_valid, lc_waddr, lc_wdata,
        input  lc_ready, FR_WE, FR_Waddr, FR_Wdata, pend_mask, dp_stall, q_count
    );

    modport slave (
        input  dp_we, dp_waddr, dp_wdata, lc_valid, lc_waddr, lc_wdata,
        output lc_ready, FR_WE, FR_Waddr, FR_Wdata, pend_mask, dp_stall, q_count
    );

endinterface

// File: rtl/wb_queue.sv
// In-order circular buffer of long-latency writes; each entry carries a live bit that
// a newer datapath write to the same register can clear.
module wb_queue
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_addr,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_squash_en,
    input  logic [ADDR_W-1:0]        i_squash_addr,
    output wb_req_t                  o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [CNT_W-1:0]         o_count,
    output logic [(1 << ADDR_W)-1:0] o_pend_mask
);

    logic [DEPTH-1:0]  r_live;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_live;

    // A same-cycle datapath write to the same register already supersedes this value.
    assign w_push_live = (i_push_addr != REG_ZERO) &&
                         !(i_squash_en && (i_squash_addr == i_push_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_squash_en && r_live[i] && (r_addr[i] == i_squash_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_live[r_wr_ptr] <= w_push_live;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed through a set live bit.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_comb begin
        o_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                o_pend_mask[r_addr[i]] = 1'b1;
            end
        end
    end

    assign o_head.we   = r_live[r_rd_ptr];
    assign o_head.addr = r_addr[r_rd_ptr];
    assign o_head.data = r_data[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_count     = r_count;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: datapath writes win, queued long-latency
// writes drain in order when the datapath is idle, with a starvation stall request.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                  w_head;
    logic                     w_empty;
    logic                     w_full;
    logic [CNT_W-1:0]         w_count;
    logic [(1 << ADDR_W)-1:0] w_pend_mask;
    logic                     w_dp_req;
    logic                     w_push;
    logic                     w_pop;

    wb_req_t                  r_fr;
    logic [STARVE_W-1:0]      r_starve;

    assign w_dp_req = bus.dp_we && (bus.dp_waddr != REG_ZERO);
    assign w_pop    = !w_dp_req && !w_empty;
    assign w_push   = bus.lc_valid && !w_full;

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_addr   (bus.lc_waddr),
        .i_push_data   (bus.lc_wdata),
        .i_pop         (w_pop),
        .i_squash_en   (w_dp_req),
        .i_squash_addr (bus.dp_waddr),
        .o_head        (w_head),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_count       (w_count),
        .o_pend_mask   (w_pend_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fr     <= '0;
            r_starve <= '0;
        end else begin
            if (w_dp_req) begin
                r_fr.we   <= 1'b1;
                r_fr.addr <= bus.dp_waddr;
                r_fr.data <= bus.dp_wdata;
            end else if (w_pop && w_head.we) begin
                r_fr <= w_head;
            end else begin
                r_fr.we <= 1'b0;
            end

            // Non-empty and not popping means the datapath took the port this cycle.
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign bus.FR_WE     = r_fr.we;
    assign bus.FR_Waddr  = r_fr.addr;
    assign bus.FR_Wdata  = r_fr.data;
    assign bus.lc_ready  = !w_full;
    assign bus.q_count   = w_count;
    assign bus.pend_mask = w_pend_mask;
    assign bus.dp_stall  = (r_starve >= STARVE_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue-based reference model checked every cycle.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) u_bus ();

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    // Reference model state
    ent_t                     mq[$];
    bit                       m_we     = 1'b0;
    logic [ADDR_W-1:0]        m_addr   = '0;
    logic [DATA_W-1:0]        m_data   = '0;
    int                       m_starve = 0;
    bit                       m_dp, m_busy, m_acc;
    ent_t                     m_head, m_new;
    logic [(1 << ADDR_W)-1:0] c_pm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_we     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_starve = 0;
        end else begin
            m_dp   = u_bus.dp_we && (u_bus.dp_waddr != 0);
            m_busy = (mq.size() != 0);
            m_acc  = u_bus.lc_valid && (mq.size() < DEPTH);
            if (m_dp) begin
                m_we   = 1'b1;
                m_addr = u_bus.dp_waddr;
                m_data = u_bus.dp_wdata;
                foreach (mq[i]) begin
                    if (mq[i].addr == u_bus.dp_waddr) mq[i].live = 1'b0;
                end
            end else if (m_busy) begin
                m_head = mq.pop_front();
                m_we   = m_head.live;
                if (m_head.live) begin
                    m_addr = m_head.addr;
                    m_data = m_head.data;
                end
            end else begin
                m_we = 1'b0;
            end
            m_starve = (m_busy && m_dp) ? m_starve + 1 : 0;
            if (m_acc) begin
                m_new.live = (u_bus.lc_waddr != 0) &&
                             !(m_dp && (u_bus.lc_waddr == u_bus.dp_waddr));
                m_new.addr = u_bus.lc_waddr;
                m_new.data = u_bus.lc_wdata;
                mq.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        c_pm = '0;
        foreach (mq[i]) begin
            if (mq[i].live) c_pm[mq[i].addr] = 1'b1;
        end
        check("cyc_fr_we", u_bus.FR_WE, m_we);
        if (m_we) begin
            check("cyc_fr_addr", u_bus.FR_Waddr, m_addr);
            check("cyc_fr_data", u_bus.FR_Wdata, m_data);
        end
        check("cyc_q_count", u_bus.q_count, mq.size());
        check("cyc_lc_ready", u_bus.lc_ready, mq.size() < DEPTH);
        check("cyc_pend_mask", u_bus.pend_mask, c_pm);
        check("cyc_dp_stall", u_bus.dp_stall, m_starve >= STARVE_LIMIT);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit dv, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                         input bit lv, input logic [ADDR_W-1:0] la,
                         input logic [DATA_W-1:0] ld);
        u_bus.dp_we    = dv;
        u_bus.dp_waddr = da;
        u_bus.dp_wdata = dd;
        u_bus.lc_valid = lv;
        u_bus.lc_waddr = la;
        u_bus.lc_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        idle();
        #1;
        check("rst_fr_we", u_bus.FR_WE, 0);
        check("rst_fr_data", u_bus.FR_Wdata, 0);
        check("rst_lc_ready", u_bus.lc_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Single datapath write, latency one
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        tick();
        idle();
        check("dp_we", u_bus.FR_WE, 1);
        check("dp_addr", u_bus.FR_Waddr, 5);
        check("dp_data", u_bus.FR_Wdata, 32'hDEADBEEF);
        tick();
        check("dp_done", u_bus.FR_WE, 0);
        check("dp_hold_addr", u_bus.FR_Waddr, 5);

        // Four long-latency results with the datapath idle
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, 1'b1, 5'(8 + k), 32'(32'h100 + k));
            tick();
            if (k == 0) check("lc_pend_first", u_bus.pend_mask, 32'h100);
            if (k == 1) begin
                check("lc_first_addr", u_bus.FR_Waddr, 8);
                check("lc_first_data", u_bus.FR_Wdata, 32'h100);
            end
        end
        idle();
        tick();
        check("lc_last_addr", u_bus.FR_Waddr, 11);
        check("lc_last_data", u_bus.FR_Wdata, 32'h103);
        check("lc_drained", u_bus.q_count, 0);
        tick();

        // WAW squash
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
        tick();
        check("sq_pend", u_bus.pend_mask, 32'h80);
        drive(1'b1, 5'd7, 32'h11, 1'b0, '0, '0);
        tick();
        idle();
        check("sq_dp_addr", u_bus.FR_Waddr, 7);
        check("sq_dp_data", u_bus.FR_Wdata, 32'h11);
        check("sq_pend_clr", u_bus.pend_mask, 0);
        check("sq_q_dead", u_bus.q_count, 1);
        tick();
        check("sq_dead_pop", u_bus.FR_WE, 0);
        check("sq_q_empty", u_bus.q_count, 0);

        // Register 0 from both sources
        drive(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        tick();
        idle();
        check("r0_dp_we", u_bus.FR_WE, 0);
        check("r0_q", u_bus.q_count, 1);
        check("r0_pend", u_bus.pend_mask, 0);
        tick();
        check("r0_pop_we", u_bus.FR_WE, 0);

        // Fill to DEPTH behind a busy datapath
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd3, 32'(32'h300 + k), 1'b1, 5'(8 + k), 32'(32'h200 + k));
            tick();
        end
        check("full_q", u_bus.q_count, 4);
        check("full_ready", u_bus.lc_ready, 0);
        check("full_pend", u_bus.pend_mask, 32'h0F00);
        drive(1'b1, 5'd3, 32'h304, 1'b1, 5'd12, 32'h2FF);
        tick();
        check("full_reject", u_bus.q_count, 4);
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_addr", u_bus.FR_Waddr, 8 + k);
            check("drain_data", u_bus.FR_Wdata, 32'h200 + k);
        end
        check("drain_q", u_bus.q_count, 0);

        // Starvation
        drive(1'b1, 5'd3, 32'h500, 1'b1, 5'd12, 32'hC0);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 5'd3, 32'(32'h501 + k), 1'b0, '0, '0);
            tick();
            if (k == 6) check("starve_pre", u_bus.dp_stall, 0);
            if (k == 7) check("starve_rise", u_bus.dp_stall, 1);
            if (k == 8) begin
                check("starve_dp_wins", u_bus.FR_Waddr, 3);
                check("starve_hold", u_bus.dp_stall, 1);
            end
        end
        idle();
        tick();
        check("starve_head_we", u_bus.FR_WE, 1);
        check("starve_head_addr", u_bus.FR_Waddr, 12);
        check("starve_head_data", u_bus.FR_Wdata, 32'hC0);
        check("starve_fall", u_bus.dp_stall, 0);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd3, 32'(32'h600 + k), 1'b1, 5'(13 + k), 32'(32'hD0 + k));
            tick();
        end
        check("rst_pre_q", u_bus.q_count, 3);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", u_bus.FR_WE, 0);
        check("rst_mid_addr", u_bus.FR_Waddr, 0);
        check("rst_mid_data", u_bus.FR_Wdata, 0);
        check("rst_mid_q", u_bus.q_count, 0);
        check("rst_mid_pend", u_bus.pend_mask, 0);
        check("rst_mid_ready", u_bus.lc_ready, 1);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_post_we", u_bus.FR_WE, 0);
        check("rst_post_q", u_bus.q_count, 0);
        tick();
        check("rst_post_we2", u_bus.FR_WE, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sits directly upstream of the register file and is the only driver of its write port (FR_WE/FR_Waddr/FR_Wdata).
- Merges two write-back sources:
  - the single-cycle datapath (ALU/load result), which has priority and is never refused;
  - a long-latency unit (multiply/divide, slow load) through a small in-order queue with valid/ready handshake.
- Publishes a pending-write scoreboard so decode can stall on hazards.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 4, long-latency queue entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles a queued head may lose arbitration before dp_stall asserts

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- dp_we  input  1  datapath write request this cycle
- dp_waddr  input  ADDR_W  datapath destination register
- dp_wdata  input  DATA_W  datapath write data
- lc_valid  input  1  long-latency result valid
- lc_ready  output  1  queue can accept (count < DEPTH)
- lc_waddr  input  ADDR_W  long-latency destination register
- lc_wdata  input  DATA_W  long-latency write data
- FR_WE  output  1  register file write enable (registered)
- FR_Waddr  output  ADDR_W  register file write address (registered)
- FR_Wdata  output  DATA_W  register file write data (registered)
- pend_mask  output  2**ADDR_W  bit r set when a live queued write targets register r
- dp_stall  output  1  request for the core to hold dp_we low
- q_count  output  clog2(DEPTH)+1  live queue occupancy, including squashed entries

Behaviour:
- Reset (async, rst_n=0):
  - FR_WE=0, FR_Waddr=0, FR_Wdata=0.
  - Queue empty, q_count=0, pend_mask=0, starve counter=0, dp_stall=0, lc_ready=1.
- Register 0:
  - Writes to address 0 are never issued.
  - dp_we with dp_waddr=0 is treated as no request.
  - lc accepts to address 0 are enqueued as dead entries.
- Enqueue:
  - Occurs when lc_valid && lc_ready at the rising edge.
  - lc_ready depends on q_count only; there is no same-cycle bypass when full.
- Arbitration (evaluated each cycle; the result is registered onto FR_* at the next edge):
  - dp_we and dp_waddr != 0: issue dp; FR_* is valid one cycle after dp_we (latency 1).
  - Otherwise, if the queue is non-empty: pop the head. Issue it if live; if dead, pop with FR_WE=0.
  - Otherwise: FR_WE=0; FR_Waddr/FR_Wdata hold their previous values.
  - Minimum latency from lc accept to FR_WE is 2 cycles.
- Squash (WAW ordering):
  - When dp issues to register r, every live queued entry with waddr=r becomes dead in the same edge.
  - An entry enqueued in the same cycle with lc_waddr=r is also dead.
  - The newer datapath value must never be overwritten by an older long-latency value.
- pend_mask:
  - OR of one-hot(waddr) over live entries; bit 0 is always 0.
  - Updated at the same edge as enqueue, pop, or squash.
- Starvation:
  - The counter increments each cycle the queue is non-empty and dp wins. It clears on any pop or when the queue is empty.
  - dp_stall = (counter >= STARVE_LIMIT), combinational from the counter.
  - If dp_we is still asserted while dp_stall=1, dp still wins. Datapath writes are never dropped.
- Simultaneous enqueue and pop: q_count unchanged; queue order preserved.
- Pointer wrap: read/write pointers wrap modulo DEPTH.
- Reset mid-operation: all queued entries are discarded, and no FR_WE pulse is produced on the cycle after deassertion.

Decomposition:
- Shared package regfile_pkg:
  - localparams DATA_W and ADDR_W;
  - typedef wb_req_t {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;};
  - constant REG_ZERO = 0.
- One sub-module, wb_queue: DEPTH-entry circular buffer storing {live, addr, data}. It has:
  - push/pop ports;
  - a squash_en/squash_addr port that clears matching live bits;
  - count and pend_mask outputs.
- The arbiter, starvation counter and output register stay in regfile_wb_arbiter.

Test Plan:
- dp_we=1, dp_waddr=5, dp_wdata=0xDEADBEEF for one cycle -> next cycle FR_WE=1, FR_Waddr=5, FR_Wdata=0xDEADBEEF; then FR_WE=0.
- lc_valid for 4 results (regs 8..11, data 0x100..0x103) with dp idle -> all accepted, lc_ready=0 only when q_count=4, FR writes to 8,9,10,11 in order, pend_mask bits 8..11 clear one per pop.
- Enqueue lc write to reg 7 (0x77), then dp write to reg 7 (0x11) before it drains -> FR writes only 7<-0x11, dead entry pops with FR_WE=0, pend_mask[7]=0 right after the squash.
- dp_we to reg 0, and an lc write to reg 0 -> FR_WE never asserts for either; pend_mask[0] stays 0.
- Queue holds one entry while dp_we is continuous to reg 3 -> dp_stall rises after 8 cycles; core drops dp_we -> head issues next cycle, dp_stall falls.
- Fill the queue to 3, pulse rst_n low mid-cycle -> outputs zero immediately, q_count=0, pend_mask=0, no FR_WE after release.
